// File: rtl/nonrestoring_divider_32bit_pkg.sv
// rtl/nonrestoring_divider_32bit_pkg.sv - shared state encoding and constants for the 32-bit divider
package nonrestoring_divider_32bit_pkg;

   localparam int WIDTH      = 32;
   localparam int ITER_COUNT = 32;

   localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [WIDTH-1:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_e;

endpackage

// File: rtl/nonrestoring_divider_32bit_div_nr_step.sv
// rtl/nonrestoring_divider_32bit_div_nr_step.sv - one combinational non-restoring division step
module div_nr_step
   import nonrestoring_divider_32bit_pkg::*;
(
   input  logic [WIDTH:0]   prem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   prem_o,
   output logic             qbit_o
);

   logic [WIDTH:0] shifted;

   // Wraparound in the shift is harmless: the result always lands in [-D, D).
   always_comb begin
      shifted = {prem_i[WIDTH-1:0], bit_i};
      if (prem_i[WIDTH]) begin
         prem_o = shifted + {1'b0, divisor_i};
      end else begin
         prem_o = shifted - {1'b0, divisor_i};
      end
      qbit_o = ~prem_o[WIDTH];
   end

endmodule

// File: rtl/nonrestoring_divider_32bit.sv
// rtl/nonrestoring_divider_32bit.sv - iterative signed/unsigned 32-bit divider, one quotient bit per cycle
// Optional DIV_BY_ZERO_FLAG_EN adds the div_by_zero output.
module nonrestoring_divider_32bit
   import nonrestoring_divider_32bit_pkg::state_e,
          nonrestoring_divider_32bit_pkg::IDLE,
          nonrestoring_divider_32bit_pkg::PREP,
          nonrestoring_divider_32bit_pkg::ITER,
          nonrestoring_divider_32bit_pkg::FIX,
          nonrestoring_divider_32bit_pkg::DONE,
          nonrestoring_divider_32bit_pkg::ITER_COUNT,
          nonrestoring_divider_32bit_pkg::DIV0_QUOT,
          nonrestoring_divider_32bit_pkg::INT_MIN;
#(
   parameter int WIDTH = nonrestoring_divider_32bit_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done
`ifdef DIV_BY_ZERO_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   state_e           state_q;
   logic [5:0]       cnt_q;
   logic             signed_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] dvs_mag_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH:0]   prem_q;
   logic             qneg_q;
   logic             rneg_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] dvd_mag_d;
   logic [WIDTH-1:0] dvs_mag_d;
   logic [WIDTH-1:0] rem_mag_d;
   logic [WIDTH:0]   step_prem_d;
   logic             step_qbit_d;

   always_comb begin
      dvd_mag_d = (signed_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
      dvs_mag_d = (signed_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
      // Low bits of the corrected remainder; the sign bit is known to clear.
      rem_mag_d = prem_q[WIDTH-1:0] + (prem_q[WIDTH] ? dvs_mag_q : '0);
   end

   div_nr_step u_step (
      .prem_i    (prem_q),
      .bit_i     (quo_q[WIDTH-1]),
      .divisor_i (dvs_mag_q),
      .prem_o    (step_prem_d),
      .qbit_o    (step_qbit_d)
   );

`ifdef DIV_BY_ZERO_FLAG_EN
   logic div_by_zero_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_by_zero_q <= 1'b0;
      end else if (state_q == IDLE && start) begin
         div_by_zero_q <= 1'b0;
      end else if (state_q == DONE) begin
         div_by_zero_q <= (dvs_q == '0);
      end
   end

   assign div_by_zero = div_by_zero_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         signed_q    <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         dvs_mag_q   <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         prem_q      <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_q    <= dividend;
                  dvs_q    <= divisor;
                  signed_q <= is_signed;
                  busy_q   <= 1'b1;
                  state_q  <= PREP;
               end
            end
            PREP: begin
               cnt_q     <= '0;
               prem_q    <= '0;
               dvs_mag_q <= dvs_mag_d;
               qneg_q    <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
               rneg_q    <= signed_q & dvd_q[WIDTH-1];
               if (dvs_q == '0) begin
                  quo_q   <= DIV0_QUOT;
                  rem_q   <= dvd_q;
                  state_q <= DONE;
               end else if (signed_q && dvd_q == INT_MIN && dvs_q == '1) begin
                  quo_q   <= INT_MIN;
                  rem_q   <= '0;
                  state_q <= DONE;
               end else begin
                  quo_q   <= dvd_mag_d;
                  state_q <= ITER;
               end
            end
            ITER: begin
               prem_q <= step_prem_d;
               quo_q  <= {quo_q[WIDTH-2:0], step_qbit_d};
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == 6'(ITER_COUNT - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quo_q   <= qneg_q ? -quo_q : quo_q;
               rem_q   <= rneg_q ? -rem_mag_d : rem_mag_d;
               state_q <= DONE;
            end
            DONE: begin
               quotient_q  <= quo_q;
               remainder_q <= rem_q;
               done_q      <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
